// File: rtl/measure_rx_pkg.sv
// Shared measurement-traffic definitions: XGMII control codes, frame field
// positions and the rate-window defaults used by both the TX and RX sides.
package measure_rx_pkg;

  localparam logic [7:0]  XGMII_START    = 8'hfb;
  localparam logic [7:0]  XGMII_TERM     = 8'hfd;
  localparam logic [7:0]  XGMII_IDLE     = 8'h07;
  localparam logic [63:0] XGMII_PREAMBLE = {56'hd5555555555555, XGMII_START};

  localparam logic [7:0] WORD_IP_SRC = 8'd4;
  localparam logic [7:0] WORD_MAGIC  = 8'd6;
  localparam logic [7:0] WORD_TS_LO  = 8'd7;
  localparam logic [7:0] WORD_MAX    = 8'd255;

  localparam int unsigned SEC_CYCLES_DEFAULT = 156_250_000;
  localparam logic [39:0] MAGIC_CODE_DEFAULT = 40'h0123456789;

  typedef enum logic {
    ST_IDLE,
    ST_FRAME
  } rx_state_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hffff_ffff : s[31:0];
  endfunction

endpackage

// File: rtl/measure_rx_if.sv
// XGMII receive stream plus shared counter in, measurement results out.
interface measure_rx_if;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic [31:0] global_counter;
  logic [31:0] rx_pps;
  logic [31:0] rx_throughput;
  logic [23:0] rx_latency;
  logic [31:0] rx_ipv4_ip;

  modport master (
    output xgmii_rxd, xgmii_rxc, global_counter,
    input  rx_pps, rx_throughput, rx_latency, rx_ipv4_ip
  );

  modport slave (
    input  xgmii_rxd, xgmii_rxc, global_counter,
    output rx_pps, rx_throughput, rx_latency, rx_ipv4_ip
  );
endinterface

// File: rtl/measure_rx_sec_window.sv
// Free-running measurement window: one-cycle tick every SEC_CYCLES cycles,
// first tick SEC_CYCLES cycles after reset release.
module sec_window
  import measure_rx_pkg::*;
#(
  parameter int unsigned SEC_CYCLES = SEC_CYCLES_DEFAULT
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic tick
);

  localparam logic [31:0] RELOAD = 32'(SEC_CYCLES - 1);

  logic [31:0] count;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || count == '0) begin
      count <= RELOAD;
    end else begin
      count <= count - 32'd1;
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/measure_rx.sv
// Receive side of the measurement generator: finds magic-tagged UDP frames on
// XGMII, reports one-way latency, source IP and per-window frame/byte rates.
module measure_rx
  import measure_rx_pkg::*;
#(
  parameter logic [39:0] MAGIC_CODE = MAGIC_CODE_DEFAULT,
  parameter int unsigned SEC_CYCLES = SEC_CYCLES_DEFAULT
) (
  input logic         sys_clk,
  input logic         sys_rst,
  measure_rx_if.slave rx
);

  rx_state_t   state;
  logic [7:0]  word_idx;
  logic        magic_hit;
  logic        ts_lo_ok;
  logic [31:0] ip_src;
  logic [31:0] ts;
  logic [31:0] gc_rx;
  logic [31:0] pps_acc;
  logic [31:0] byte_acc;
  logic [31:0] pps_q;
  logic [31:0] tput_q;
  logic [23:0] lat_q;
  logic [31:0] ip_q;
  logic        tick;

  logic        is_start;
  logic        is_data;
  logic [2:0]  ctl_lane;
  logic [7:0]  ctl_char;
  logic [7:0]  next_idx;
  logic [11:0] frame_bytes;
  logic        commit;
  logic [31:0] lat_diff;
  logic [31:0] add_pps;
  logic [31:0] add_bytes;

  sec_window #(.SEC_CYCLES(SEC_CYCLES)) u_window (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .tick    (tick)
  );

  // Byte count is derived from the word index and terminate lane rather than
  // kept as a separate running counter.
  always_comb begin
    is_start = (rx.xgmii_rxc == 8'h01) && (rx.xgmii_rxd == XGMII_PREAMBLE);
    is_data  = (rx.xgmii_rxc == '0);
    ctl_lane = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (rx.xgmii_rxc[3'(i - 1)]) ctl_lane = 3'(i - 1);
    end
    ctl_char    = rx.xgmii_rxd[{ctl_lane, 3'b000} +: 8];
    next_idx    = word_idx + 8'd1;
    frame_bytes = {1'b0, word_idx, 3'b000} + {9'd0, ctl_lane};
    commit      = (state == ST_FRAME) && !is_start && !is_data &&
                  (ctl_char == XGMII_TERM) && magic_hit && ts_lo_ok;
    lat_diff    = gc_rx - ts;
    add_pps     = {31'd0, commit};
    add_bytes   = commit ? {20'd0, frame_bytes} : '0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      word_idx  <= '0;
      magic_hit <= 1'b0;
      ts_lo_ok  <= 1'b0;
      ip_src    <= '0;
      ts        <= '0;
      gc_rx     <= '0;
      pps_acc   <= '0;
      byte_acc  <= '0;
      pps_q     <= '0;
      tput_q    <= '0;
      lat_q     <= '0;
      ip_q      <= '0;
    end else begin
      if (is_start) begin
        state     <= ST_FRAME;
        word_idx  <= '0;
        magic_hit <= 1'b0;
        ts_lo_ok  <= 1'b0;
      end else if (state == ST_FRAME) begin
        if (is_data) begin
          word_idx <= next_idx;
          if (next_idx == WORD_MAX) state <= ST_IDLE;
          if (next_idx == WORD_IP_SRC) begin
            ip_src <= {rx.xgmii_rxd[23:16], rx.xgmii_rxd[31:24],
                       rx.xgmii_rxd[39:32], rx.xgmii_rxd[47:40]};
          end
          if (next_idx == WORD_MAGIC) begin
            magic_hit <= ({rx.xgmii_rxd[23:16], rx.xgmii_rxd[31:24], rx.xgmii_rxd[39:32],
                           rx.xgmii_rxd[47:40], rx.xgmii_rxd[55:48]} == MAGIC_CODE);
            ts[31:24] <= rx.xgmii_rxd[63:56];
          end
          if (next_idx == WORD_TS_LO) begin
            ts[23:0] <= {rx.xgmii_rxd[7:0], rx.xgmii_rxd[15:8], rx.xgmii_rxd[23:16]};
            gc_rx    <= rx.global_counter;
            ts_lo_ok <= 1'b1;
          end
        end else begin
          state <= ST_IDLE;
        end
      end

      if (commit) begin
        lat_q <= (lat_diff > 32'h00ff_ffff) ? 24'hff_ffff : lat_diff[23:0];
        ip_q  <= ip_src;
      end

      // A commit landing on the tick belongs to the window being closed.
      if (tick) begin
        pps_q    <= sat_add32(pps_acc, add_pps);
        tput_q   <= sat_add32(byte_acc, add_bytes);
        pps_acc  <= '0;
        byte_acc <= '0;
      end else begin
        pps_acc  <= sat_add32(pps_acc, add_pps);
        byte_acc <= sat_add32(byte_acc, add_bytes);
      end
    end
  end

  assign rx.rx_pps        = pps_q;
  assign rx.rx_throughput = tput_q;
  assign rx.rx_latency    = lat_q;
  assign rx.rx_ipv4_ip    = ip_q;

endmodule

// File: tb/tb_measure_rx.sv
// Frame-level bench for measure_rx: builds byte-level frames, predicts the
// committed results from field offsets and window arithmetic, and compares every cycle.
module tb_measure_rx;
  import measure_rx_pkg::*;

  localparam int unsigned SEC   = 1000;
  localparam logic [39:0] MAGIC = 40'h0123456789;
  localparam int END_TERM = 0;
  localparam int END_ERR  = 1;
  localparam int END_NONE = 2;

  logic sys_clk;
  logic sys_rst;

  measure_rx_if bus();

  measure_rx #(.MAGIC_CODE(MAGIC), .SEC_CYCLES(SEC)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .rx      (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int          tests_run;
  int          tests_failed;
  int unsigned n_edges;
  logic [31:0] gc;
  logic [31:0] exp_pps, exp_tput, exp_ip, acc_pps, acc_bytes;
  logic [23:0] exp_lat;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check_eq("pps",  64'(bus.rx_pps),        64'(exp_pps));
    check_eq("tput", 64'(bus.rx_throughput), 64'(exp_tput));
    check_eq("lat",  64'(bus.rx_latency),    64'(exp_lat));
    check_eq("ip",   64'(bus.rx_ipv4_ip),    64'(exp_ip));
  endtask

  task automatic send_word(input logic [63:0] d, input logic [7:0] c, input bit cm,
                           input logic [23:0] lat, input logic [31:0] ip, input int nb);
    bus.xgmii_rxd      = d;
    bus.xgmii_rxc      = c;
    bus.global_counter = gc;
    @(posedge sys_clk);
    n_edges++;
    gc++;
    if (cm) begin
      exp_lat   = lat;
      exp_ip    = ip;
      acc_pps   = acc_pps + 32'd1;
      acc_bytes = acc_bytes + 32'(nb);
    end
    if (n_edges % SEC == 0) begin
      exp_pps   = acc_pps;
      exp_tput  = acc_bytes;
      acc_pps   = '0;
      acc_bytes = '0;
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_word({8{XGMII_IDLE}}, 8'hff, 1'b0, '0, '0, 0);
  endtask

  task automatic wait_tick();
    idle(1);
    while (n_edges % SEC != 0) idle(1);
  endtask

  task automatic do_reset();
    sys_rst            = 1'b1;
    bus.xgmii_rxd      = {8{XGMII_IDLE}};
    bus.xgmii_rxc      = 8'hff;
    bus.global_counter = gc;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst   = 1'b0;
    n_edges   = 0;
    exp_pps   = '0;
    exp_tput  = '0;
    exp_lat   = '0;
    exp_ip    = '0;
    acc_pps   = '0;
    acc_bytes = '0;
    check_outputs();
  endtask

  // Frame bytes include the FCS; ip at 26..29, magic at 42..46, ts at 47..50.
  task automatic send_frame(input int len, input logic [39:0] magic, input logic [31:0] ts,
                            input logic [31:0] ip, input logic [31:0] gc_w7, input int ending);
    logic [7:0]  fr [];
    logic [63:0] d;
    logic [7:0]  c;
    logic [31:0] diff;
    logic [23:0] lat;
    int          nfull, r;
    bit          matched;
    fr = new[len];
    foreach (fr[i]) fr[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) if (26 + i < len) fr[26 + i] = ip[31 - 8 * i -: 8];
    for (int i = 0; i < 5; i++) if (42 + i < len) fr[42 + i] = magic[39 - 8 * i -: 8];
    for (int i = 0; i < 4; i++) if (47 + i < len) fr[47 + i] = ts[31 - 8 * i -: 8];
    nfull   = len / 8;
    r       = len % 8;
    matched = (ending == END_TERM) && (len >= 56) && (magic == MAGIC) && (nfull < 255);
    diff    = gc_w7 - ts;
    lat     = (diff > 32'h00ff_ffff) ? 24'hff_ffff : diff[23:0];
    gc      = gc_w7 - 32'd7;
    send_word(XGMII_PREAMBLE, 8'h01, 1'b0, '0, '0, 0);
    for (int w = 0; w < nfull; w++) begin
      for (int l = 0; l < 8; l++) d[8 * l +: 8] = fr[8 * w + l];
      send_word(d, 8'h00, 1'b0, '0, '0, 0);
    end
    if (ending != END_NONE) begin
      for (int l = 0; l < 8; l++) begin
        if (l < r) begin
          d[8 * l +: 8] = fr[8 * nfull + l];
          c[l] = 1'b0;
        end else if (l == r) begin
          d[8 * l +: 8] = (ending == END_TERM) ? XGMII_TERM : 8'hfe;
          c[l] = 1'b1;
        end else begin
          d[8 * l +: 8] = XGMII_IDLE;
          c[l] = 1'b1;
        end
      end
      send_word(d, c, matched, lat, ip, len);
    end
  endtask

  initial begin
    int          len, ending;
    logic [39:0] mg;
    logic [31:0] ts_r;
    tests_run    = 0;
    tests_failed = 0;
    gc           = 32'h0000_0100;
    sys_rst      = 1'b1;

    do_reset();
    check_eq("rst_pps", 64'(bus.rx_pps), 64'd0);
    check_eq("rst_lat", 64'(bus.rx_latency), 64'd0);

    send_frame(64, MAGIC, 32'h0000_1000, 32'h0a00_0001, 32'h0000_1234, END_TERM);
    check_eq("basic_lat", 64'(bus.rx_latency), 64'h000234);
    check_eq("basic_ip",  64'(bus.rx_ipv4_ip), 64'h0a000001);
    wait_tick();
    check_eq("win1_pps", 64'(bus.rx_pps), 64'd1);

    for (int i = 0; i < 10; i++) begin
      send_frame(64, MAGIC, 32'h0000_1000, 32'h0a00_0001, 32'h0000_1234, END_TERM);
      idle(1);
    end
    wait_tick();
    check_eq("win10_pps",  64'(bus.rx_pps), 64'd10);
    check_eq("win10_tput", 64'(bus.rx_throughput), 64'd640);
    wait_tick();
    check_eq("empty_pps",  64'(bus.rx_pps), 64'd0);
    check_eq("empty_tput", 64'(bus.rx_throughput), 64'd0);

    send_frame(64, 40'h0123456788, 32'h0000_2000, 32'h0b00_0002, 32'h0000_2100, END_TERM);
    idle(1);
    send_frame(48, MAGIC, 32'h0000_2000, 32'h0b00_0002, 32'h0000_2100, END_TERM);
    idle(1);
    send_frame(44, MAGIC, 32'h0000_2000, 32'h0b00_0002, 32'h0000_2100, END_TERM);
    idle(1);
    check_eq("nomatch_lat", 64'(bus.rx_latency), 64'h000234);
    wait_tick();
    check_eq("nomatch_pps", 64'(bus.rx_pps), 64'd0);

    send_frame(64, MAGIC, 32'h0000_2000, 32'hc0a8_0101, 32'h0000_1000, END_TERM);
    check_eq("wrap_lat", 64'(bus.rx_latency), 64'hffffff);
    idle(2);
    send_frame(64, MAGIC, 32'hffff_ff00, 32'hc0a8_0102, 32'h0000_0010, END_TERM);
    check_eq("modulo_lat", 64'(bus.rx_latency), 64'h000110);
    idle(2);
    send_frame(68, MAGIC, 32'h0000_1000, 32'hc0a8_0103, 32'h0000_1234, END_TERM);
    wait_tick();
    check_eq("bound_pps",  64'(bus.rx_pps), 64'd3);
    check_eq("bound_tput", 64'(bus.rx_throughput), 64'd196);

    send_frame(64, MAGIC, 32'h0000_3000, 32'h0c00_0001, 32'h0000_3010, END_ERR);
    idle(1);
    send_frame(64, MAGIC, 32'h0000_4000, 32'h0c00_0002, 32'h0000_4111, END_NONE);
    send_frame(64, MAGIC, 32'h0000_5000, 32'h0c00_0003, 32'h0000_5077, END_TERM);
    check_eq("restart_lat", 64'(bus.rx_latency), 64'h000077);
    check_eq("restart_ip",  64'(bus.rx_ipv4_ip), 64'h0c000003);
    wait_tick();
    check_eq("abort_pps",  64'(bus.rx_pps), 64'd1);
    check_eq("abort_tput", 64'(bus.rx_throughput), 64'd64);

    send_frame(32, MAGIC, 32'h0000_6000, 32'h0d00_0001, 32'h0000_6020, END_NONE);
    do_reset();
    send_word({{7{XGMII_IDLE}}, XGMII_TERM}, 8'hff, 1'b0, '0, '0, 0);
    check_eq("midrst_lat", 64'(bus.rx_latency), 64'd0);
    check_eq("midrst_ip",  64'(bus.rx_ipv4_ip), 64'd0);

    while (n_edges % SEC != SEC - 10) idle(1);
    send_frame(64, MAGIC, 32'h0000_7000, 32'h0e00_0001, 32'h0000_7005, END_TERM);
    check_eq("tickco_pps",  64'(bus.rx_pps), 64'd1);
    check_eq("tickco_tput", 64'(bus.rx_throughput), 64'd64);

    for (int f = 0; f < 120; f++) begin
      case ($urandom_range(0, 5))
        0:       len = 44;
        1:       len = 48;
        2:       len = 55;
        3:       len = 56;
        4:       len = 64;
        default: len = int'($urandom_range(57, 200));
      endcase
      ending = ($urandom_range(0, 7) < 6) ? END_TERM : (($urandom_range(0, 1) == 0) ? END_ERR : END_NONE);
      if (ending == END_NONE) len = len & ~7;
      mg   = ($urandom_range(0, 4) != 0) ? MAGIC : (MAGIC ^ (40'h1 << $urandom_range(0, 39)));
      ts_r = $urandom;
      send_frame(len, mg, ts_r, $urandom,
                 ($urandom_range(0, 1) == 0) ? ts_r + 32'($urandom_range(0, 32'h01ff_ffff)) : $urandom,
                 ending);
      idle(int'($urandom_range(0, 3)));
    end
    send_frame(2048, MAGIC, 32'h0000_8000, 32'h0f00_0001, 32'h0000_8001, END_TERM);
    wait_tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/measure_rx.md
# measure_rx

Receive-side counterpart of the measurement traffic generator. Parses a 64-bit XGMII receive stream and recognises measurement UDP frames by their 40-bit magic code. For each such frame it extracts the embedded 32-bit transmit timestamp and the IPv4 source address. It reports one-way latency against the shared free-running `global_counter`, plus per-second frame and byte rates, to the PCI user registers.

## Interface
Parameters:
- `MAGIC_CODE`, default `` `MAGIC_CODE `` (40 bits): signature matched in measurement frames.
- `SEC_CYCLES`, default 156_250_000: measurement window length in `sys_clk` cycles.

Ports:
- `sys_clk`, input, 1: 156.25 MHz XGMII clock; the only clock.
- `sys_rst`, input, 1: reset; synchronous, active-high.
- `xgmii_rxd`, input, 64: RX data; lane n is bits [8n+7:8n], and lane 0 is first on the wire.
- `xgmii_rxc`, input, 8: RX control; bit n flags lane n.
- `global_counter`, input, 32: free-running cycle count, shared with the transmitter.
- `rx_pps`, output, 32: matched frames in the last completed window.
- `rx_throughput`, output, 32: matched-frame bytes in the last completed window.
- `rx_latency`, output, 24: latency of the last matched frame, in cycles.
- `rx_ipv4_ip`, output, 32: IPv4 source address of the last matched frame.

## Operation
Start word:
- `xgmii_rxc == 8'h01` and `xgmii_rxd == 64'hd5555555555555fb`.
- Frame byte 0 (first destination-MAC byte) is lane 0 of the next word.
- Word k after the start word carries frame bytes 8(k-1) through 8(k-1)+7.

FSM states:
- IDLE to FRAME on a start word. Clear the word index to 0, and clear the byte count and the match flags.
- FRAME to IDLE on a terminate: the lowest lane with its `rxc` bit set holds `8'hfd`.
  - Byte count = 8 × (data words) + lane index of `fd`; the FCS is included.
  - Commit the frame if matched (below).
- FRAME to IDLE, no commit, on any other control character in the lowest flagged lane.
- A start word inside FRAME aborts the current frame (no commit) and begins a new one.
- FRAME to IDLE, no commit, if the word index reaches 255 (frame too long).

Field extraction (k = data-word index, 1-based):
- k=4: `ip_src = {lane2, lane3, lane4, lane5}`.
- k=6: magic hit when `{lane2..lane6} == MAGIC_CODE`, with lane2 the MSB. Capture `ts[31:24] = lane7`.
- k=7: capture `ts[23:0] = {lane0, lane1, lane2}`. Capture `gc_rx = global_counter` in the same cycle.
- Matched = magic hit AND word 7 received as all data AND terminate seen.

Commit (on the terminate cycle):
- `diff = gc_rx - ts`, modulo 2^32.
- `rx_latency <= (diff > 24'hffffff) ? 24'hffffff : diff[23:0]`.
- `rx_ipv4_ip <= ip_src`.
- `pps_acc += 1`; `byte_acc += byte count`. Both accumulators saturate at 2^32-1.

Measurement window:
- Down-counter reloads with `SEC_CYCLES-1`; the tick fires at 0.
- On the tick: `rx_pps <= pps_acc + commit`, `rx_throughput <= byte_acc + bytes_if_commit`, and both accumulators clear.
- A commit in the tick cycle counts toward the closing window.
- No FCS check: CRC errors are counted as good frames.

## Timing
- Reset: all outputs 0, FSM IDLE, accumulators 0, window counter `SEC_CYCLES-1`.
- `sys_rst` mid-frame discards the frame; nothing is committed.
- `rx_latency` and `rx_ipv4_ip` are valid on the edge after the terminate word.
- Measured latency = wire time from word 7 at the transmitter to word 7 at this block, both on the shared counter.
- Rate outputs update on the edge after the tick. They hold between ticks and are never partial.
- First tick: `SEC_CYCLES` cycles after reset deassertion.
- Back-to-back frames are supported: a terminate in word n and a start in word n+1 both take effect.
- No stall or backpressure: one word per cycle, always.

## Structure
Shared package (common with the transmitter):
- XGMII control constants: `START=8'hfb`, `TERM=8'hfd`, `IDLE=8'h07`.
- Preamble word.
- Field word indices 4, 6, 7.
- Default `SEC_CYCLES`.

Sub-module `sec_window`:
- Down-counter that emits the one-cycle tick.
- Reusable by the transmitter's rate counters.

## Test plan
Sim uses `SEC_CYCLES=1000`, `MAGIC_CODE=40'h0123456789`.
- **Matched frame:** 64-byte measurement frame, src 10.0.0.1, ts 0x00001000, word 7 arriving at `global_counter=0x00001234`. Expect `rx_latency=0x000234` and `rx_ipv4_ip=32'h0a000001` one cycle after terminate.
- **Window totals:** 10 such 64-byte frames, back-to-back with one idle word, in one window. After the tick, expect `rx_pps=10` and `rx_throughput=640`. With no traffic in the next window, expect both to read 0 after that window's tick.
- **Non-matching frames:** wrong magic (last byte `8'h88`), plus a 48-byte frame terminating in word 6. Expect no counts and no latency update.
- **Boundaries:**
  - ts ahead of `gc_rx` (wrap): expect `rx_latency=24'hffffff`.
  - ts `32'hffffff00`, `gc_rx` `32'h00000010`: expect `rx_latency=0x000110`.
  - Terminate at lane 4: expect 4 bytes added beyond the full words.
- **Abort and edge cases:**
  - `8'hfe` error character mid-frame: no commit.
  - New start inside a frame: only the second frame is committed.
  - `sys_rst` during word 5: all outputs 0, nothing committed.
- **Tick coincidence:** terminate in the tick cycle; expect that frame included in the closing window's `rx_pps`.
